// File: rtl/phi_generator_if.sv
// Control and PHI2/strobe bundle between the PHI2 generator and its user.
// period_load is a one-clock strobe; there is no back-pressure, every strobe is captured.
interface phi_generator_if #(
   parameter int guard_bits = 4
);
   logic                  enable;
   logic [7:0]            period_int;
   logic [guard_bits-1:0] period_frac;
   logic                  period_load;
   logic                  phi2_out;
   logic                  running;
   logic                  full_m2;
   logic                  full_m1;
   logic                  full_p0;
   logic                  full_p1;
   logic                  half_m2;
   logic                  half_m1;
   logic                  half_p0;
   logic                  half_p1;
   logic [15:0]           cycle_count;

   modport master (
      output enable, period_int, period_frac, period_load,
      input  phi2_out, running, full_m2, full_m1, full_p0, full_p1,
             half_m2, half_m1, half_p0, half_p1, cycle_count
   );

   modport slave (
      input  enable, period_int, period_frac, period_load,
      output phi2_out, running, full_m2, full_m1, full_p0, full_p1,
             half_m2, half_m1, half_p0, half_p1, cycle_count
   );
endinterface

// File: rtl/phi_generator.sv
// Standalone PHI2 source: fractional-NCO period, glitch-free boundary updates,
// and the same cycle-phase strobe set as the recovered-clock path.
module phi_generator #(
   parameter int                    guard_bits   = 4,
   parameter logic [7:0]            default_int  = 8'd31,
   parameter logic [guard_bits-1:0] default_frac = '0
) (
   input logic             clk,
   input logic             reset_n,
   phi_generator_if.slave  bus
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [8:0]            cnt_q, cnt_d;
   logic [8:0]            last_q, last_d;
   logic [8:0]            h_q, h_d;
   logic [guard_bits-1:0] acc_q, acc_d;
   logic [7:0]            int_sh_q, int_sh_d;
   logic [guard_bits-1:0] frac_sh_q, frac_sh_d;
   logic [15:0]           cc_q, cc_d;
   logic                  phi2_q, phi2_d;
   logic                  running_q, running_d;
   logic                  fm2_q, fm2_d, fm1_q, fm1_d, fp0_q, fp0_d, fp1_q, fp1_d;
   logic                  hm2_q, hm2_d, hm1_q, hm1_d, hp0_q, hp0_d, hp1_q, hp1_d;

   logic [7:0]            eff_p;
   logic [guard_bits:0]   acc_sum;
   logic [8:0]            start_last;
   logic [8:0]            start_h;

   // Next-cycle parameters, used only at the edge that lands on cnt = 0.
   always_comb begin
      eff_p      = (int_sh_q < 8'd7) ? 8'd7 : int_sh_q;
      acc_sum    = {1'b0, acc_q} + {1'b0, frac_sh_q};
      start_last = {1'b0, eff_p} + {8'd0, acc_sum[guard_bits]};
      start_h    = {2'b00, eff_p[7:1]} + 9'd1;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      h_d       = h_q;
      acc_d     = acc_q;
      cc_d      = cc_q;
      int_sh_d  = int_sh_q;
      frac_sh_d = frac_sh_q;

      if (bus.period_load) begin
         int_sh_d  = bus.period_int;
         frac_sh_d = bus.period_frac;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = 9'd0;
            if (bus.enable) begin
               state_d = S_RUN;
               last_d  = start_last;
               h_d     = start_h;
               acc_d   = acc_sum[guard_bits-1:0];
            end
         end
         default: begin
            if (cnt_q == last_q) begin
               cnt_d = 9'd0;
               cc_d  = cc_q + 16'd1;
               if (bus.enable) begin
                  last_d = start_last;
                  h_d    = start_h;
                  acc_d  = acc_sum[guard_bits-1:0];
               end else begin
                  state_d = S_IDLE;
                  acc_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
      endcase

      // Outputs are decoded from the next state so the registered copies line up with cnt_q.
      running_d = (state_d == S_RUN);
      phi2_d    = running_d && (cnt_d >= h_d);
      fm2_d     = running_d && (cnt_d == last_d - 9'd1);
      fm1_d     = running_d && (cnt_d == last_d);
      fp0_d     = running_d && (cnt_d == 9'd0);
      fp1_d     = running_d && (cnt_d == 9'd1);
      hm2_d     = running_d && (cnt_d == h_d - 9'd2);
      hm1_d     = running_d && (cnt_d == h_d - 9'd1);
      hp0_d     = running_d && (cnt_d == h_d);
      hp1_d     = running_d && (cnt_d == h_d + 9'd1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 9'd0;
         last_q    <= 9'd0;
         h_q       <= 9'd0;
         acc_q     <= '0;
         cc_q      <= 16'd0;
         int_sh_q  <= default_int;
         frac_sh_q <= default_frac;
         running_q <= 1'b0;
         phi2_q    <= 1'b0;
         fm2_q     <= 1'b0;
         fm1_q     <= 1'b0;
         fp0_q     <= 1'b0;
         fp1_q     <= 1'b0;
         hm2_q     <= 1'b0;
         hm1_q     <= 1'b0;
         hp0_q     <= 1'b0;
         hp1_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         h_q       <= h_d;
         acc_q     <= acc_d;
         cc_q      <= cc_d;
         int_sh_q  <= int_sh_d;
         frac_sh_q <= frac_sh_d;
         running_q <= running_d;
         phi2_q    <= phi2_d;
         fm2_q     <= fm2_d;
         fm1_q     <= fm1_d;
         fp0_q     <= fp0_d;
         fp1_q     <= fp1_d;
         hm2_q     <= hm2_d;
         hm1_q     <= hm1_d;
         hp0_q     <= hp0_d;
         hp1_q     <= hp1_d;
      end
   end

   assign bus.phi2_out    = phi2_q;
   assign bus.running     = running_q;
   assign bus.full_m2     = fm2_q;
   assign bus.full_m1     = fm1_q;
   assign bus.full_p0     = fp0_q;
   assign bus.full_p1     = fp1_q;
   assign bus.half_m2     = hm2_q;
   assign bus.half_m1     = hm1_q;
   assign bus.half_p0     = hp0_q;
   assign bus.half_p1     = hp1_q;
   assign bus.cycle_count = cc_q;

endmodule

// File: tb/tb_phi_generator.sv
// Directed bench for phi_generator: per-clock expected output vectors are queued
// per PHI2 cycle and compared against the DUT at each falling clock edge.
module tb_phi_generator;
   localparam int GB = 4;
   localparam int W  = 26;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   phi_generator_if #(.guard_bits(GB)) bus ();

   phi_generator #(
      .guard_bits  (GB),
      .default_int (8'd31),
      .default_frac(4'd0)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   logic [W-1:0] exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    exp_cc = 0;
   string tag    = "reset";

   // {running, phi2, full_m2, full_m1, full_p0, full_p1, half_m2, half_m1, half_p0, half_p1, cycle_count}
   function automatic logic [W-1:0] mk(input bit run, input int cnt, input int last,
                                       input int h, input int cc);
      logic [9:0]  s;
      logic [15:0] c;
      c = cc[15:0];
      if (!run) s = '0;
      else s = {1'b1, (cnt >= h), (cnt == last - 1), (cnt == last), (cnt == 0),
                (cnt == 1), (cnt == h - 2), (cnt == h - 1), (cnt == h), (cnt == h + 1)};
      return {s, c};
   endfunction

   function automatic logic [W-1:0] observe();
      return {bus.running, bus.phi2_out, bus.full_m2, bus.full_m1, bus.full_p0, bus.full_p1,
              bus.half_m2, bus.half_m1, bus.half_p0, bus.half_p1, bus.cycle_count};
   endfunction

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 0, 0, 0, exp_cc));
   endtask

   // p = effective period integer, carry = NCO carry for this cycle, n = clocks to expect.
   task automatic push_cycle(input int p, input int carry, input int n);
      int last;
      int h;
      last = p + carry;
      h    = (p / 2) + 1;
      for (int c = 0; c < n; c++) exp_q.push_back(mk(1'b1, c, last, h, exp_cc));
      if (n == last + 1) exp_cc++;
   endtask

   task automatic compare();
      logic [W-1:0] obs;
      logic [W-1:0] exp;
      obs = observe();
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard_empty obs=%h", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         compare();
      end
   endtask

   task automatic load(input int p, input int f);
      bus.period_int  = p[7:0];
      bus.period_frac = f[GB-1:0];
      bus.period_load = 1'b1;
      tick(1);
      bus.period_load = 1'b0;
   endtask

   initial begin
      bus.enable      = 1'b0;
      bus.period_int  = 8'd0;
      bus.period_frac = '0;
      bus.period_load = 1'b0;
      reset_n         = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      push_idle(1);
      compare();
      @(negedge clk);
      reset_n = 1'b1;
      tag = "idle";
      push_idle(2);
      tick(2);

      // Default P=31, then a mid-cycle load of 15 that must wait for the boundary.
      tag = "p31_load15";
      bus.enable = 1'b1;
      push_cycle(31, 0, 32);
      push_cycle(15, 0, 16);
      tick(5);
      load(15, 0);
      tick(42);

      // P=9, F=0.5: alternating 10/11 clock cycles.
      tag = "frac";
      push_cycle(15, 0, 16);
      push_cycle(9, 0, 10);
      push_cycle(9, 1, 11);
      push_cycle(9, 0, 10);
      push_cycle(9, 1, 11);
      tick(3);
      load(9, 8);
      tick(54);

      // P=3 clamps to 7.
      tag = "clamp";
      push_cycle(9, 0, 10);
      push_cycle(7, 0, 8);
      push_cycle(7, 0, 8);
      tick(2);
      load(3, 0);
      tick(23);

      // Back to 32 clocks, drop enable at cnt 5; cycle completes, then idle.
      tag = "stop";
      push_cycle(7, 0, 8);
      push_cycle(31, 0, 32);
      tick(2);
      load(31, 0);
      tick(10);
      bus.enable = 1'b0;
      tick(27);
      push_idle(3);
      tick(3);

      // Restart, load a non-default shadow, then reset asynchronously at cnt 20.
      tag = "restart";
      bus.enable = 1'b1;
      push_cycle(31, 0, 21);
      tick(5);
      load(15, 0);
      tick(15);
      tag = "async_reset";
      #2 reset_n = 1'b0;
      #1;
      exp_cc = 0;
      push_idle(1);
      compare();
      bus.enable = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      push_idle(1);
      tick(1);

      // Shadow must be back at the default 32-clock period.
      tag = "default_shadow";
      bus.enable = 1'b1;
      push_cycle(31, 0, 32);
      tick(32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
